// File: rtl/osnt_snapper_pkg.sv
// Shared types and helpers for the per-port packet snapper.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package osnt_snapper_pkg;

  // Packet-level FSM states.
  typedef enum logic [1:0] {
    SOP  = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  // TUSER field positions.
  localparam int LEN_LO = 0;
  localparam int LEN_HI = 15;
  localparam int SRC_LO = 16;
  localparam int SRC_HI = 23;

  // Widest supported stream (1024 bits) in bytes.
  localparam int MAX_BYTES = 128;

  // Contiguous LSB-first byte enables covering nbytes, clipped to the bus width.
  function automatic logic [MAX_BYTES-1:0] keep_mask(input int nbytes, input int bytes);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if ((i < nbytes) && (i < bytes)) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/osnt_snapper_out_reg.sv
// One-entry AXI-Stream output register; the only storage on the snapper data path.
// Latency: 1 cycle from i_load to o_tvalid.
// Backpressure: entry held until i_tready; caller must load only when empty or draining.
// Ports: i_clk/i_rst (sync, active high), i_load + i_t* beat in, o_t* beat out, i_tready from downstream.
module osnt_snapper_out_reg #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic [DATA_WIDTH-1:0]   i_tdata,
  input  logic [DATA_WIDTH/8-1:0] i_tkeep,
  input  logic [TUSER_WIDTH-1:0]  i_tuser,
  input  logic                    i_tlast,
  input  logic                    i_tready,
  output logic [DATA_WIDTH-1:0]   o_tdata,
  output logic [DATA_WIDTH/8-1:0] o_tkeep,
  output logic [TUSER_WIDTH-1:0]  o_tuser,
  output logic                    o_tlast,
  output logic                    o_tvalid
);

  logic [DATA_WIDTH-1:0]   r_tdata;
  logic [DATA_WIDTH/8-1:0] r_tkeep;
  logic [TUSER_WIDTH-1:0]  r_tuser;
  logic                    r_tlast;
  logic                    r_tvalid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tuser  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else if (i_load) begin
      r_tdata  <= i_tdata;
      r_tkeep  <= i_tkeep;
      r_tuser  <= i_tuser;
      r_tlast  <= i_tlast;
      r_tvalid <= 1'b1;
    end else if (i_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign o_tdata  = r_tdata;
  assign o_tkeep  = r_tkeep;
  assign o_tuser  = r_tuser;
  assign o_tlast  = r_tlast;
  assign o_tvalid = r_tvalid;

endmodule

// File: rtl/osnt_sume_packet_snapper.sv
// Truncates each AXI-Stream packet to a per-source-port snap length, rewriting TKEEP and TUSER length.
// Latency: 1 cycle (single output register stage).
// Backpressure: s_axis_tready follows output-register space; beats being dropped are always accepted.
// Ports: axi_aclk/axi_reset (sync, active high); s_axis_* in; m_axis_* out; cut_en, snap_len (per port),
//        stat_clr config. Optional build macro OSNT_SNAPPER_STATS_EN adds pkt_in_cnt/pkt_out_cnt/pkt_cut_cnt.
module osnt_sume_packet_snapper
  import osnt_snapper_pkg::*;
#(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128,
  parameter int NUM_PORTS   = 8,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                           axi_aclk,
  input  logic                           axi_reset,
  input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0]         s_axis_tuser,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]        m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]         m_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  input  logic                           cut_en,
  input  logic [NUM_PORTS*LEN_WIDTH-1:0] snap_len,
  input  logic                           stat_clr
`ifdef OSNT_SNAPPER_STATS_EN
  ,
  output logic [31:0]                    pkt_in_cnt,
  output logic [31:0]                    pkt_out_cnt,
  output logic [31:0]                    pkt_cut_cnt
`endif
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LEN_F = LEN_HI - LEN_LO + 1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LEN_WIDTH-1:0]   r_byte_cnt;
  logic [LEN_WIDTH-1:0]   r_eff_len;

  logic                   w_acc;
  logic                   w_load;
  logic                   w_cut;
  logic                   w_port_vld;
  logic [2:0]             w_port_idx;
  logic [LEN_WIDTH-1:0]   w_snap_sel;
  logic [LEN_WIDTH-1:0]   w_eff_len;
  logic [LEN_WIDTH-1:0]   w_cnt;
  logic [LEN_WIDTH-1:0]   w_cnt_sat;
  logic [LEN_WIDTH-1:0]   w_cut_len;
  logic [LEN_WIDTH-1:0]   w_pkt_len;
  logic [LEN_WIDTH:0]     w_beat_bytes;
  logic [LEN_WIDTH:0]     w_sum_full;
  logic [LEN_WIDTH:0]     w_sum_last;
  logic [MAX_BYTES-1:0]   w_mask_full;
  logic [BYTES-1:0]       w_out_keep;
  logic                   w_out_last;
  logic [TUSER_WIDTH-1:0] w_out_user;

  assign s_axis_tready = (r_state == DROP) | ~m_axis_tvalid | m_axis_tready;
  assign w_acc         = s_axis_tvalid & s_axis_tready;

  // Lowest set source-port bit wins.
  always_comb begin
    w_port_vld = 1'b0;
    w_port_idx = '0;
    for (int i = SRC_HI - SRC_LO; i >= 0; i--) begin
      if (s_axis_tuser[SRC_LO + i]) begin
        w_port_vld = 1'b1;
        w_port_idx = 3'(i);
      end
    end
  end

  // Ports without a table entry fall through with zero, i.e. never cut.
  always_comb begin
    w_snap_sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_port_vld && (w_port_idx == 3'(i))) begin
        w_snap_sel = snap_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  always_comb begin
    w_beat_bytes = '0;
    for (int i = 0; i < BYTES; i++) begin
      w_beat_bytes = w_beat_bytes + (LEN_WIDTH+1)'(s_axis_tkeep[i]);
    end
  end

  // On the SOP beat the live config applies; later beats use the value latched at SOP.
  assign w_eff_len  = (r_state == SOP) ? (cut_en ? w_snap_sel : '0) : r_eff_len;
  assign w_cnt      = (r_state == SOP) ? '0 : r_byte_cnt;
  assign w_pkt_len  = LEN_WIDTH'(s_axis_tuser[LEN_HI:LEN_LO]);

  // Sums kept one bit wider so the comparison stays correct near the saturation point.
  assign w_sum_full = {1'b0, w_cnt} + (LEN_WIDTH+1)'(BYTES);
  assign w_sum_last = {1'b0, w_cnt} + w_beat_bytes;
  assign w_cnt_sat  = w_sum_full[LEN_WIDTH] ? '1 : w_sum_full[LEN_WIDTH-1:0];

  // Non-final beats are full, so only the final beat needs its real byte count.
  assign w_cut = (r_state != DROP) && (w_eff_len != '0) &&
                 (s_axis_tlast ? (w_sum_last >  {1'b0, w_eff_len})
                               : (w_sum_full >= {1'b0, w_eff_len}));

  // Never cut before the current beat, so this difference is always in 1..BYTES.
  assign w_cut_len   = w_eff_len - w_cnt;
  assign w_mask_full = keep_mask(int'(w_cut_len), BYTES);

  // FSM: state register.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      r_state <= SOP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state.
  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) begin
      if (s_axis_tlast) begin
        w_state_nxt = SOP;
      end else if ((r_state == DROP) || w_cut) begin
        w_state_nxt = DROP;
      end else begin
        w_state_nxt = PASS;
      end
    end
  end

  // FSM: outputs.
  always_comb begin
    w_load     = w_acc && (r_state != DROP);
    w_out_keep = s_axis_tkeep;
    w_out_last = s_axis_tlast;
    w_out_user = s_axis_tuser;
    if (w_cut) begin
      w_out_keep = w_mask_full[BYTES-1:0];
      w_out_last = 1'b1;
    end
    // The header length tells at SOP whether this packet will be cut.
    if ((r_state == SOP) && (w_eff_len != '0) && (w_pkt_len > w_eff_len)) begin
      w_out_user[LEN_HI:LEN_LO] = LEN_F'(w_eff_len);
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      r_byte_cnt <= '0;
      r_eff_len  <= '0;
    end else if (w_acc) begin
      if (s_axis_tlast) begin
        r_byte_cnt <= '0;
      end else if (r_state != DROP) begin
        r_byte_cnt <= w_cnt_sat;
      end
      if (r_state == SOP) begin
        r_eff_len <= w_eff_len;
      end
    end
  end

  osnt_snapper_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .TUSER_WIDTH(TUSER_WIDTH)
  ) u_out_reg (
    .i_clk   (axi_aclk),
    .i_rst   (axi_reset),
    .i_load  (w_load),
    .i_tdata (s_axis_tdata),
    .i_tkeep (w_out_keep),
    .i_tuser (w_out_user),
    .i_tlast (w_out_last),
    .i_tready(m_axis_tready),
    .o_tdata (m_axis_tdata),
    .o_tkeep (m_axis_tkeep),
    .o_tuser (m_axis_tuser),
    .o_tlast (m_axis_tlast),
    .o_tvalid(m_axis_tvalid)
  );

`ifdef OSNT_SNAPPER_STATS_EN
  logic [31:0] r_pkt_in_cnt;
  logic [31:0] r_pkt_out_cnt;
  logic [31:0] r_pkt_cut_cnt;

  always_ff @(posedge axi_aclk) begin
    if (axi_reset || stat_clr) begin
      r_pkt_in_cnt  <= '0;
      r_pkt_out_cnt <= '0;
      r_pkt_cut_cnt <= '0;
    end else begin
      if (w_acc && s_axis_tlast) begin
        r_pkt_in_cnt <= r_pkt_in_cnt + 32'd1;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        r_pkt_out_cnt <= r_pkt_out_cnt + 32'd1;
      end
      if (w_acc && w_cut) begin
        r_pkt_cut_cnt <= r_pkt_cut_cnt + 32'd1;
      end
    end
  end

  assign pkt_in_cnt  = r_pkt_in_cnt;
  assign pkt_out_cnt = r_pkt_out_cnt;
  assign pkt_cut_cnt = r_pkt_cut_cnt;
`endif

  // Upper mask bits beyond the bus width and, without statistics, stat_clr have no consumer.
  logic w_unused_ok;
  assign w_unused_ok = ^{w_mask_full, stat_clr};

endmodule
